harmonic_sequencer: RTL
=======================

# harmonic_sequencer

Frame-level controller for the additive-synthesis harmonic attenuator. On each sample tick it restarts the scale multiplier with the frame's initial level, then steps it once per harmonic. Each resulting level is handed to the downstream accumulator over a valid/ready handshake, tagged with its harmonic index. It sits between the sample-rate timing generator and the Scale_Mult / accumulator datapath.

## Interface
- `DIV_BIT`, default 11: level / scale / initial width, matching the multiplier.
- `HARM_BIT`, default 8: harmonic index and count width.

Ports (one clock; reset is asynchronous and active-low):
- `i_Clock`  in  1  system clock.
- `i_Reset_N`  in  1  asynchronous active-low reset.
- `i_Sample_Tick`  in  1  one-cycle frame start strobe.
- `i_Harmonic_Count`  in  HARM_BIT  harmonics per frame; sampled on accepted tick.
- `i_Initial`  in  DIV_BIT  fundamental level; sampled on accepted tick.
- `i_Scale`  in  DIV_BIT  per-harmonic decrement; sampled on accepted tick.
- `o_Mult_Initial`  out  DIV_BIT  latched initial value to multiplier.
- `o_Mult_Scale`  out  DIV_BIT  latched scale value to multiplier.
- `o_Mult_Restart`  out  1  multiplier restart pulse.
- `o_Mult_Start`  out  1  multiplier step pulse.
- `i_Mult_Ready`  in  1  multiplier ready.
- `i_Mult`  in  DIV_BIT  multiplier current level.
- `o_Level_Valid`  out  1  level/harmonic valid.
- `i_Accum_Ready`  in  1  accumulator ready; transfer when both valid and ready are high.
- `o_Level`  out  DIV_BIT  harmonic level.
- `o_Harmonic`  out  HARM_BIT  harmonic index, 0 = fundamental.
- `o_Busy`  out  1  high in every state except IDLE.
- `o_Frame_Done`  out  1  one-cycle end-of-frame pulse.
- `o_Overrun`  out  1  one-cycle pulse: tick arrived while busy.

## Operation
- All outputs are registered. Every output resets to 0. The state resets to IDLE.
- **IDLE**
  - Tick with count = 0: go to DONE. No restart and no emits.
  - Tick with count > 0: latch count, `o_Mult_Initial`, `o_Mult_Scale`; clear `o_Harmonic`; go to RESTART.
- **RESTART**: `o_Mult_Restart` = 1 for this cycle; go to LOAD.
- **LOAD**: one settle cycle; go to EMIT, loading `o_Level` <= `i_Mult` and `o_Level_Valid` <= 1.
- **EMIT**: hold `o_Level`, `o_Harmonic` and valid stable until transfer. On transfer:
  - Valid drops.
  - If `o_Harmonic` = count-1: go to DONE.
  - Otherwise: go to STEP.
- **STEP**: `o_Mult_Start` = 1 for this cycle; `o_Harmonic` increments; go to WAIT.
- **WAIT**: on `i_Mult_Ready` = 1, go to EMIT, loading `o_Level` <= `i_Mult` and setting valid.
  - `i_Mult_Ready` is low in the first WAIT cycle; this is required and relied upon.
- **DONE**: `o_Frame_Done` = 1 for this cycle; go to IDLE.
- **Tick while not IDLE**
  - `o_Overrun` pulses the following cycle.
  - The tick and its count/initial/scale inputs are discarded.
  - The current frame completes unaffected.
- `o_Harmonic` never wraps. Count is at most 2^HARM_BIT-1, so the last index fits.
- **Reset mid-frame**: immediate return to IDLE; outputs cleared. The multiplier is not reset by this block; it is reinitialised by the next frame's restart.

## Timing
- Tick sampled in cycle T: RESTART in T+1, LOAD in T+2, first valid in T+3 with `o_Level` = initial and `o_Harmonic` = 0.
- Transfer in cycle E: Start pulse in E+1, WAIT in E+2..E+3, next valid in E+4.
- Harmonic period is 4 cycles with no backpressure.
- For N harmonics with no backpressure: `o_Frame_Done` in T+4N; next tick accepted from T+4N+1.
- Backpressure adds one cycle per cycle valid is held without ready.
- Count = 0: `o_Frame_Done` in T+1.

## Configuration
- `HARM_EARLY_STOP_EN` defined: a transfer with `o_Level` = 0 ends the frame.
  - Next state is DONE regardless of remaining count.
  - No further Start pulses are issued.
- Undefined: exactly count levels are emitted per frame, zeros included.

## Test plan
- Initial=2000, Scale=300, count=4, ready tied high -> levels 2000,1700,1400,1100 on harmonics 0..3; valid in T+3, T+7, T+11, T+15; Frame_Done in T+16.
- Initial=500, Scale=200, count=8 -> with EN: 500,300,100,0 then Frame_Done; without EN: 500,300,100,0,0,0,0,0.
- Ready held low 5 cycles on harmonic 1 -> level and index held stable; no Start pulse until transfer; frame extends by 5 cycles.
- Second tick 6 cycles after the first -> `o_Overrun` one-cycle pulse; harmonic sequence and Frame_Done timing unchanged; new Initial ignored.
- Count=0 tick -> Frame_Done in T+1; no Restart, no Start, no valid.
- Reset asserted while in WAIT on harmonic 2 -> all outputs 0 asynchronously. After release, tick with Initial=1000, Scale=100 -> first level 1000.

Source files
------------

// File: rtl/harmonic_sequencer.sv
// Frame controller for the harmonic attenuator: restarts the scale multiplier per tick, then emits one level per harmonic.
// Latency: first level valid 3 cycles after an accepted tick; 4-cycle harmonic period without backpressure.
// Backpressure: level/harmonic held on o_Level_Valid until i_Accum_Ready; optional HARM_EARLY_STOP_EN ends a frame on a zero level.
module harmonic_sequencer #(
    parameter int DIV_BIT  = 11,
    parameter int HARM_BIT = 8
) (
    input  logic                i_Clock,
    input  logic                i_Reset_N,
    input  logic                i_Sample_Tick,
    input  logic [HARM_BIT-1:0] i_Harmonic_Count,
    input  logic [DIV_BIT-1:0]  i_Initial,
    input  logic [DIV_BIT-1:0]  i_Scale,
    output logic [DIV_BIT-1:0]  o_Mult_Initial,
    output logic [DIV_BIT-1:0]  o_Mult_Scale,
    output logic                o_Mult_Restart,
    output logic                o_Mult_Start,
    input  logic                i_Mult_Ready,
    input  logic [DIV_BIT-1:0]  i_Mult,
    output logic                o_Level_Valid,
    input  logic                i_Accum_Ready,
    output logic [DIV_BIT-1:0]  o_Level,
    output logic [HARM_BIT-1:0] o_Harmonic,
    output logic                o_Busy,
    output logic                o_Frame_Done,
    output logic                o_Overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_RESTART, S_LOAD, S_EMIT, S_STEP, S_WAIT, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [HARM_BIT-1:0] r_count;

    logic w_tick_idle;
    logic w_xfer;
    logic w_last;
    logic w_latch;
    logic w_load_level;
    logic w_advance;
    logic w_restart;
    logic w_start;
    logic w_valid;
    logic w_busy;
    logic w_done;
    logic w_overrun;

    assign w_tick_idle = i_Sample_Tick && (r_state == S_IDLE);
    // Valid is only ever high in EMIT, so this is the accepted transfer.
    assign w_xfer      = o_Level_Valid && i_Accum_Ready;

`ifdef HARM_EARLY_STOP_EN
    // A zero level means every later harmonic would also be silent.
    assign w_last = (o_Harmonic == (r_count - HARM_BIT'(1))) || (o_Level == '0);
`else
    assign w_last = (o_Harmonic == (r_count - HARM_BIT'(1)));
`endif

    // State register
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_Sample_Tick) begin
                    w_next = (i_Harmonic_Count == '0) ? S_DONE : S_RESTART;
                end
            end
            S_RESTART: w_next = S_LOAD;
            S_LOAD:    w_next = S_EMIT;
            S_EMIT: begin
                if (w_xfer) w_next = w_last ? S_DONE : S_STEP;
            end
            S_STEP:    w_next = S_WAIT;
            S_WAIT: begin
                if (i_Mult_Ready) w_next = S_EMIT;
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Output decode: next-cycle values for the registered outputs
    always_comb begin
        w_latch      = w_tick_idle && (i_Harmonic_Count != '0);
        w_load_level = (w_next == S_EMIT) && (r_state != S_EMIT);
        w_advance    = (r_state == S_EMIT) && (w_next == S_STEP);
        w_restart    = (w_next == S_RESTART);
        w_start      = (w_next == S_STEP);
        w_valid      = (w_next == S_EMIT);
        w_busy       = (w_next != S_IDLE);
        w_done       = (w_next == S_DONE);
        w_overrun    = i_Sample_Tick && (r_state != S_IDLE);
    end

    // Output and frame-parameter registers
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            r_count        <= '0;
            o_Mult_Initial <= '0;
            o_Mult_Scale   <= '0;
            o_Mult_Restart <= 1'b0;
            o_Mult_Start   <= 1'b0;
            o_Level_Valid  <= 1'b0;
            o_Level        <= '0;
            o_Harmonic     <= '0;
            o_Busy         <= 1'b0;
            o_Frame_Done   <= 1'b0;
            o_Overrun      <= 1'b0;
        end else begin
            if (w_latch) begin
                r_count        <= i_Harmonic_Count;
                o_Mult_Initial <= i_Initial;
                o_Mult_Scale   <= i_Scale;
                o_Harmonic     <= '0;
            end else if (w_advance) begin
                o_Harmonic     <= o_Harmonic + HARM_BIT'(1);
            end
            if (w_load_level) o_Level <= i_Mult;
            o_Mult_Restart <= w_restart;
            o_Mult_Start   <= w_start;
            o_Level_Valid  <= w_valid;
            o_Busy         <= w_busy;
            o_Frame_Done   <= w_done;
            o_Overrun      <= w_overrun;
        end
    end

endmodule
